// File: rtl/qspi_mem_pkg.sv
// Shared definitions for the QSPI memory responder: QPI command codes,
// frame phase lengths and the protocol FSM state encoding.
package qspi_mem_pkg;

    localparam logic [7:0] CMD_QREAD   = 8'hEB;
    localparam logic [7:0] CMD_QWRITE  = 8'h38;
    localparam int         CMD_NIBBLES = 2;
    localparam int         ADR_NIBBLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/qspi_mem_array.sv
// Byte-wide memory with one write port and one registered read port.
// Contents are deliberately not reset so preloaded images survive rst_i.
module qspi_mem_array #(
    parameter int MEMBYTES = 4096
) (
    input  logic                        clk_i,
    input  logic                        we_i,
    input  logic [$clog2(MEMBYTES)-1:0] wadr_i,
    input  logic [7:0]                  wdat_i,
    input  logic [$clog2(MEMBYTES)-1:0] radr_i,
    output logic [7:0]                  rdat_o
);

    logic [7:0] mem [MEMBYTES];
    logic [7:0] rdat_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wadr_i] <= wdat_i;
        end
        rdat_q <= mem[radr_i];
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/qspi_mem_responder.sv
// Device side of a QPI memory link: oversamples CS/SCK/SD on clk_i, decodes
// quad read (EB) and quad write (38) frames and serves them from a byte array.
module qspi_mem_responder
    import qspi_mem_pkg::*;
#(
    parameter int MEMBYTES = 4096,
    parameter int WRITABLE = 1,
    parameter int DUMMY    = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cs_in,
    input  logic                        sck_i,
    input  logic [3:0]                  sd_i,
    output logic [3:0]                  sd_o,
    output logic [3:0]                  sd_oen_o,
    input  logic                        ld_we_i,
    input  logic [$clog2(MEMBYTES)-1:0] ld_adr_i,
    input  logic [7:0]                  ld_dat_i
);

    localparam int AW = $clog2(MEMBYTES);
    localparam int DW = (DUMMY > 0) ? $clog2(DUMMY + 1) : 1;
    localparam logic [DW-1:0] DUMMY_LAST = DW'((DUMMY > 0) ? DUMMY - 1 : 0);
    localparam logic [2:0]    CMD_LAST   = 3'(CMD_NIBBLES - 1);
    localparam logic [2:0]    ADR_LAST   = 3'(ADR_NIBBLES - 1);

    logic [1:0]    cs_sync_q,  cs_sync_d;
    logic [1:0]    sck_sync_q, sck_sync_d;
    logic          sck_dly_q,  sck_dly_d;
    logic [3:0]    sd_sync0_q, sd_sync0_d;
    logic [3:0]    sd_sync1_q, sd_sync1_d;
    logic [1:0]    settle_q,   settle_d;
    logic          armed_q,    armed_d;

    state_t        state_q,    state_d;
    logic [2:0]    nib_q,      nib_d;
    logic [DW-1:0] dummy_q,    dummy_d;
    logic [7:0]    cmd_q,      cmd_d;
    logic [AW-1:0] addr_q,     addr_d;
    logic [3:0]    hi_q,       hi_d;
    logic [3:0]    sd_o_q,     sd_o_d;
    logic [3:0]    oen_q,      oen_d;

    logic          cs_s, sck_s, rise, fall;
    logic [3:0]    sd_s;
    logic [AW+3:0] adr_shift;
    logic [7:0]    wr_byte;
    logic [7:0]    rdat;
    logic          proto_we;
    logic          arr_we;
    logic [AW-1:0] arr_wadr;
    logic [7:0]    arr_wdat;

    assign cs_s  = cs_sync_q[1];
    assign sck_s = sck_sync_q[1];
    assign sd_s  = sd_sync1_q;
    assign rise  = sck_s & ~sck_dly_q;
    assign fall  = ~sck_s & sck_dly_q;

    always_comb begin
        cs_sync_d  = {cs_sync_q[0], cs_in};
        sck_sync_d = {sck_sync_q[0], sck_i};
        sck_dly_d  = sck_s;
        sd_sync0_d = sd_i;
        sd_sync1_d = sd_sync0_q;
        settle_d   = {settle_q[0], 1'b1};
        armed_d    = armed_q;
        state_d    = state_q;
        nib_d      = nib_q;
        dummy_d    = dummy_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        hi_d       = hi_q;
        sd_o_d     = sd_o_q;
        oen_d      = oen_q;
        proto_we   = 1'b0;
        adr_shift  = {addr_q, sd_s};
        wr_byte    = {hi_q, sd_s};

        if (cs_s) begin
            // Only a CS high seen after the synchronisers have flushed their
            // reset value arms the next frame, so a frame cut by reset is not resumed.
            state_d = ST_IDLE;
            nib_d   = 3'd0;
            dummy_d = '0;
            oen_d   = 4'hF;
            armed_d = settle_q[1];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d = ST_CMD;
                        armed_d = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        cmd_d = {cmd_q[3:0], sd_s};
                        if (nib_q == CMD_LAST) begin
                            nib_d   = 3'd0;
                            state_d = ST_ADDR;
                        end else begin
                            nib_d = nib_q + 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr_d = adr_shift[AW-1:0];
                        if (nib_q == ADR_LAST) begin
                            nib_d   = 3'd0;
                            dummy_d = '0;
                            if (cmd_q == CMD_QREAD) begin
                                state_d = (DUMMY == 0) ? ST_READ : ST_DUMMY;
                            end else if (cmd_q == CMD_QWRITE) begin
                                state_d = ST_WRITE;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            nib_d = nib_q + 3'd1;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (dummy_q == DUMMY_LAST) begin
                            state_d = ST_READ;
                            nib_d   = 3'd0;
                        end else begin
                            dummy_d = dummy_q + DW'(1);
                        end
                    end
                end
                ST_READ: begin
                    // The array output follows addr_q every clk, so the next
                    // byte is ready long before the next falling SCK edge.
                    if (fall) begin
                        oen_d = 4'h0;
                        if (nib_q == 3'd0) begin
                            sd_o_d = rdat[7:4];
                            nib_d  = 3'd1;
                        end else begin
                            sd_o_d = rdat[3:0];
                            nib_d  = 3'd0;
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (rise) begin
                        if (nib_q == 3'd0) begin
                            hi_d  = sd_s;
                            nib_d = 3'd1;
                        end else begin
                            proto_we = (WRITABLE != 0);
                            nib_d    = 3'd0;
                            addr_d   = addr_q + AW'(1);
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_q  <= 2'b11;
            sck_sync_q <= 2'b00;
            sck_dly_q  <= 1'b0;
            sd_sync0_q <= 4'h0;
            sd_sync1_q <= 4'h0;
            settle_q   <= 2'b00;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            nib_q      <= 3'd0;
            dummy_q    <= '0;
            cmd_q      <= 8'h00;
            addr_q     <= '0;
            hi_q       <= 4'h0;
            sd_o_q     <= 4'h0;
            oen_q      <= 4'hF;
        end else begin
            cs_sync_q  <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            sck_dly_q  <= sck_dly_d;
            sd_sync0_q <= sd_sync0_d;
            sd_sync1_q <= sd_sync1_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            nib_q      <= nib_d;
            dummy_q    <= dummy_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            hi_q       <= hi_d;
            sd_o_q     <= sd_o_d;
            oen_q      <= oen_d;
        end
    end

    // Backdoor load wins; a protocol write colliding with it is lost.
    assign arr_we   = ld_we_i | (proto_we & ~rst_i);
    assign arr_wadr = ld_we_i ? ld_adr_i : addr_q;
    assign arr_wdat = ld_we_i ? ld_dat_i : wr_byte;

    qspi_mem_array #(
        .MEMBYTES (MEMBYTES)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (arr_we),
        .wadr_i (arr_wadr),
        .wdat_i (arr_wdat),
        .radr_i (addr_q),
        .rdat_o (rdat)
    );

    assign sd_o     = sd_o_q;
    assign sd_oen_o = oen_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// Directed bench: a RAM and a ROM responder share one QPI master model and
// are checked against hand-computed read data and output-enable values.
module tb_qspi_mem_responder;
    import qspi_mem_pkg::*;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        sck;
    logic [3:0]  sd_i;
    logic        ld_we;
    logic [11:0] ld_adr;
    logic [7:0]  ld_dat;
    logic [3:0]  sdo_ram, oen_ram, sdo_rom, oen_rom;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qspi_mem_responder #(.MEMBYTES(4096), .WRITABLE(1), .DUMMY(6)) u_ram (
        .clk_i(clk), .rst_i(rst), .cs_in(cs_n), .sck_i(sck), .sd_i(sd_i),
        .sd_o(sdo_ram), .sd_oen_o(oen_ram),
        .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat)
    );

    qspi_mem_responder #(.MEMBYTES(4096), .WRITABLE(0), .DUMMY(6)) u_rom (
        .clk_i(clk), .rst_i(rst), .cs_in(cs_n), .sck_i(sck), .sd_i(sd_i),
        .sd_o(sdo_rom), .sd_oen_o(oen_rom),
        .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        ld_we  = 1'b1;
        ld_adr = a;
        ld_dat = d;
        wait_clk(1);
        ld_we  = 1'b0;
    endtask

    // One SCK period: present tx, sample both responders just before the rise.
    task automatic xfer(input logic [3:0] tx, output logic [3:0] d_ram, output logic [3:0] d_rom,
                        output logic [7:0] oe);
        sd_i = tx;
        wait_clk(HALF);
        d_ram = sdo_ram;
        d_rom = sdo_rom;
        oe    = {oen_ram, oen_rom};
        sck   = 1'b1;
        wait_clk(HALF);
        sck   = 1'b0;
    endtask

    task automatic send(input logic [3:0] tx);
        logic [3:0] a, b;
        logic [7:0] oe;
        xfer(tx, a, b, oe);
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [23:0] adr);
        cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 2; i++) send(cmd[7-4*i -: 4]);
        for (int i = 0; i < 6; i++) send(adr[23-4*i -: 4]);
    endtask

    task automatic read_frame(input logic [23:0] adr);
        logic [3:0] a, b;
        logic [7:0] oe;
        start_frame(8'hEB, adr);
        for (int i = 0; i < 6; i++) begin
            xfer(4'h0, a, b, oe);
            chk("dummy_oen", oe, 8'hFF);
        end
    endtask

    task automatic read_byte(input string tag, input logic [7:0] e_ram, input logic [7:0] e_rom);
        logic [3:0] hr, hm, lr, lm;
        logic [7:0] oe_h, oe_l;
        xfer(4'h0, hr, hm, oe_h);
        xfer(4'h0, lr, lm, oe_l);
        $display("read %s: ram=%02h rom=%02h", tag, {hr, lr}, {hm, lm});
        chk(tag, {hr, lr, hm, lm}, {e_ram, e_rom});
        chk({tag, "_oen"}, {oe_h, oe_l}, 16'h0000);
    endtask

    task automatic end_frame();
        wait_clk(HALF);
        cs_n = 1'b1;
        sd_i = 4'h0;
        wait_clk(8);
        chk("idle_oen", {oen_ram, oen_rom}, 8'hFF);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a, b;
        logic [7:0] oe;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sd_i = 4'h0;
        ld_we = 1'b0; ld_adr = '0; ld_dat = '0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(4);
        chk("rst_oen", {oen_ram, oen_rom}, 8'hFF);
        chk("rst_sdo", {sdo_ram, sdo_rom}, 8'h00);

        load(12'h000, 8'h11); load(12'h001, 8'h22);
        load(12'h002, 8'h33); load(12'h003, 8'h44);
        load(12'h010, 8'h77); load(12'h011, 8'h88);
        load(12'h020, 8'hC3); load(12'h030, 8'h55);
        load(12'h031, 8'h66); load(12'hFFF, 8'hAB);

        // Plain quad read of four preloaded bytes
        read_frame(24'h000000);
        read_byte("rd_b0", 8'h11, 8'h11);
        read_byte("rd_b1", 8'h22, 8'h22);
        read_byte("rd_b2", 8'h33, 8'h33);
        read_byte("rd_b3", 8'h44, 8'h44);
        end_frame();

        // Quad write: RAM takes it, ROM keeps its image
        start_frame(8'h38, 24'h000010);
        send(4'hA); send(4'h5); send(4'h5); send(4'hA);
        end_frame();
        read_frame(24'h000010);
        read_byte("wr_b0", 8'hA5, 8'h77);
        read_byte("wr_b1", 8'h5A, 8'h88);
        end_frame();

        // Address wrap from the top of the array
        read_frame(24'h000FFF);
        read_byte("wrap_b0", 8'hAB, 8'hAB);
        read_byte("wrap_b1", 8'h11, 8'h11);
        end_frame();

        // Unknown command: bus stays released, nothing written
        cs_n = 1'b0;
        wait_clk(4);
        send(4'h9); send(4'hF);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] nibs [10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h5, 4'hA, 4'h5, 4'hA};
            xfer(nibs[i], a, b, oe);
            chk("ign_oen", oe, 8'hFF);
        end
        end_frame();
        read_frame(24'h000020);
        read_byte("ign_b0", 8'hC3, 8'hC3);
        end_frame();

        // Partial trailing nibble is dropped
        start_frame(8'h38, 24'h000030);
        send(4'hA); send(4'h5); send(4'hF);
        end_frame();
        read_frame(24'h000030);
        read_byte("part_b0", 8'hA5, 8'h55);
        read_byte("part_b1", 8'h66, 8'h66);
        end_frame();

        // Reset during the data phase
        read_frame(24'h000000);
        read_byte("rst_b0", 8'h11, 8'h11);
        xfer(4'h0, a, b, oe);
        chk("rst_pre_nib", {a, b, oe}, 16'h2200);
        rst = 1'b1;
        wait_clk(1);
        chk("rst_mid_oen", {oen_ram, oen_rom}, 8'hFF);
        chk("rst_mid_state", {29'd0, u_ram.state_q}, {29'd0, ST_IDLE});
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 2; i++) begin
            xfer(4'h0, a, b, oe);
            chk("post_rst_oen", oe, 8'hFF);
        end
        end_frame();
        read_frame(24'h000002);
        read_byte("post_b0", 8'h33, 8'h33);
        read_byte("post_b1", 8'h44, 8'h44);
        end_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
